data_mem_ctrl: RTL and testbench

Parametrised successor to the single-cycle data RAM. It is a byte-addressable data memory behind a valid/ready request port and a one-cycle response pulse. It adds configurable depth and base address, sign/zero-extended sub-word loads, and range checking. Misaligned accesses are either faulted or split into two word beats, selected by parameter. It sits between the hart's load/store unit and an inferred word-wide synchronous RAM array.

---
 rtl/data_mem_ctrl_if.sv | 36 +++
 rtl/data_mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/data_mem_ctrl_if.sv
// Shared width/type definitions and the load/store request-response bundle
// between the hart's LSU (master) and the data memory controller (slave).
package data_mem_ctrl_pkg;
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        write_byte     = 2'd0,
        write_halfword = 2'd1,
        write_word     = 2'd2
    } write_width_t;
endpackage

interface data_mem_ctrl_if;
    import data_mem_ctrl_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [XLEN-1:0]   req_addr;
    write_width_t      req_width;
    logic              req_unsigned;
    logic [XLEN-1:0]   req_wdata;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_fault;

    modport master (
        output req_valid, req_write, req_addr, req_width, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_fault
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_width, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_fault
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Byte-addressable data memory controller: range/alignment checking, optional
// two-beat split of word-crossing accesses, sub-word load extension.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned     DEPTH_WORDS      = 256,
    parameter logic [XLEN-1:0] BASE_ADDR        = 32'h0000_0000,
    parameter bit              ALLOW_MISALIGNED = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    data_mem_ctrl_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned NB    = XLEN / 8;
    localparam int unsigned WIN_W = 2 * XLEN;

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t            state, state_nxt;
    logic              accept;
    logic [2:0]        in_size;
    logic [XLEN:0]     in_rel, in_last;
    logic              in_split, in_fault;

    logic              q_write, q_unsigned, q_fault, q_split;
    logic [2:0]        q_size;
    logic [1:0]        q_off;
    logic [IDX_W-1:0]  q_idx;
    logic [XLEN-1:0]   q_wdata;

    logic [NB-1:0]     size_mask;
    logic [XLEN-1:0]   st_data;
    logic [WIN_W-1:0]  st_win, ld_win;
    logic [2*NB-1:0]   be_win;
    logic [XLEN-1:0]   ld_low, ld_ext, lo_q;

    logic              ram_we;
    logic [NB-1:0]     ram_be;
    logic [IDX_W-1:0]  ram_idx;
    logic [XLEN-1:0]   ram_wdata, ram_q;
    logic [XLEN-1:0]   mem [DEPTH_WORDS];

    assign accept = bus.req_valid && (state == IDLE);

    // Request decode; range check done one bit wider so it cannot wrap
    always_comb begin
        case (bus.req_width)
            write_byte:     in_size = 3'd1;
            write_halfword: in_size = 3'd2;
            default:        in_size = 3'd4;
        endcase
        in_rel   = {1'b0, bus.req_addr} - {1'b0, BASE_ADDR};
        in_last  = in_rel + (XLEN+1)'(in_size) - (XLEN+1)'(1);
        in_split = ({1'b0, bus.req_addr[1:0]} + in_size) > 3'd4;
        in_fault = (bus.req_addr < BASE_ADDR)
                || (in_last >= ((XLEN+1)'(DEPTH_WORDS) << 2))
                || (in_split && !ALLOW_MISALIGNED);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            q_write    <= 1'b0;
            q_unsigned <= 1'b0;
            q_fault    <= 1'b0;
            q_split    <= 1'b0;
            q_size     <= 3'd0;
            q_off      <= 2'd0;
            q_idx      <= '0;
            q_wdata    <= '0;
        end else if (accept) begin
            q_write    <= bus.req_write;
            q_unsigned <= bus.req_unsigned;
            q_fault    <= in_fault;
            q_split    <= in_split;
            q_size     <= in_size;
            q_off      <= bus.req_addr[1:0];
            q_idx      <= in_rel[IDX_W+1:2];
            q_wdata    <= bus.req_wdata;
        end
    end

    // Lane shifting over the two-word window, for both stores and loads
    always_comb begin
        case (q_size)
            3'd1:    begin size_mask = NB'(1); st_data = XLEN'(q_wdata[7:0]);  end
            3'd2:    begin size_mask = NB'(3); st_data = XLEN'(q_wdata[15:0]); end
            default: begin size_mask = '1;     st_data = q_wdata;              end
        endcase
        st_win = WIN_W'(st_data) << {q_off, 3'b000};
        be_win = (2*NB)'(size_mask) << q_off;
        ld_win = q_split ? {ram_q, lo_q} : {XLEN'(0), ram_q};
        ld_low = XLEN'(ld_win >> {q_off, 3'b000});
        case (q_size)
            3'd1:    ld_ext = {{(XLEN-8){~q_unsigned & ld_low[7]}}, ld_low[7:0]};
            3'd2:    ld_ext = {{(XLEN-16){~q_unsigned & ld_low[15]}}, ld_low[15:0]};
            default: ld_ext = ld_low;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = in_fault ? RESP : ACC0;
            ACC0: state_nxt = q_split ? ACC1 : RESP;
            ACC1: state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_fault = 1'b0;
        bus.resp_rdata = '0;
        ram_we         = 1'b0;
        ram_be         = '0;
        ram_idx        = q_idx;
        ram_wdata      = '0;
        case (state)
            IDLE: bus.req_ready = 1'b1;
            ACC0: begin
                ram_we    = q_write;
                ram_be    = be_win[NB-1:0];
                ram_wdata = st_win[XLEN-1:0];
            end
            ACC1: begin
                ram_idx   = q_idx + IDX_W'(1);
                ram_we    = q_write;
                ram_be    = be_win[2*NB-1:NB];
                ram_wdata = st_win[WIN_W-1:XLEN];
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                bus.resp_fault = q_fault;
                bus.resp_rdata = (q_fault || q_write) ? '0 : ld_ext;
            end
            default: ;
        endcase
    end

    // First word of a split load is held while the second word is read
    always_ff @(posedge clock or posedge reset) begin
        if (reset)              lo_q <= '0;
        else if (state == ACC1) lo_q <= ram_q;
    end

    always_ff @(posedge clock) begin
        if (ram_we) begin
            for (int b = 0; b < NB; b++) begin
                if (ram_be[b]) mem[ram_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_q <= mem[ram_idx];
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed and random checks of data_mem_ctrl: one split-capable instance and
// one faulting instance with a non-zero base address.
module tb_data_mem_ctrl;
    import data_mem_ctrl_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [7:0] mdl [0:1023];

    always #5 clock = ~clock;

    data_mem_ctrl_if if_a ();
    data_mem_ctrl_if if_f ();

    data_mem_ctrl #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .ALLOW_MISALIGNED(1'b1))
        u_dut_a (.clock(clock), .reset(reset), .bus(if_a.slave));
    data_mem_ctrl #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0000_1000), .ALLOW_MISALIGNED(1'b0))
        u_dut_f (.clock(clock), .reset(reset), .bus(if_f.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic v, input logic w, input logic [31:0] a,
                         input write_width_t wd, input logic u, input logic [31:0] wdat);
        if (d == 0) begin
            if_a.req_valid = v; if_a.req_write = w; if_a.req_addr = a;
            if_a.req_width = wd; if_a.req_unsigned = u; if_a.req_wdata = wdat;
        end else begin
            if_f.req_valid = v; if_f.req_write = w; if_f.req_addr = a;
            if_f.req_width = wd; if_f.req_unsigned = u; if_f.req_wdata = wdat;
        end
    endtask

    function automatic logic get_ready(input int d);
        return (d == 0) ? if_a.req_ready : if_f.req_ready;
    endfunction
    function automatic logic get_rv(input int d);
        return (d == 0) ? if_a.resp_valid : if_f.resp_valid;
    endfunction
    function automatic logic get_rf(input int d);
        return (d == 0) ? if_a.resp_fault : if_f.resp_fault;
    endfunction
    function automatic logic [31:0] get_rd(input int d);
        return (d == 0) ? if_a.resp_rdata : if_f.resp_rdata;
    endfunction

    function automatic int size_of(input write_width_t wd);
        return (wd == write_byte) ? 1 : (wd == write_halfword) ? 2 : 4;
    endfunction

    // One request: push the expectation at acceptance, pop it at the response
    task automatic xact(input string tag, input int d, input logic w, input logic [31:0] a,
                        input write_width_t wd, input logic u, input logic [31:0] wdat,
                        input logic [31:0] exp_rd, input logic exp_f);
        exp_t e, got;
        int   lat, to;
        @(negedge clock);
        drive(d, 1'b1, w, a, wd, u, wdat);
        to = 0;
        while (!get_ready(d) && to < 20) begin @(negedge clock); to++; end
        @(posedge clock);
        #1;
        drive(d, 1'b0, ~w, $urandom, write_word, ~u, $urandom);
        e.rdata = exp_rd;
        e.fault = exp_f;
        e.lat   = exp_f ? 1 : ((int'(a[1:0]) + size_of(wd) > 4) ? 3 : 2);
        sb.push_back(e);
        lat = 0;
        do begin @(negedge clock); lat++; end while (!get_rv(d) && lat < 10);
        got = sb.pop_front();
        check({tag, ".valid"}, 32'(get_rv(d)), 32'd1);
        check({tag, ".lat"}, lat, got.lat);
        check({tag, ".rdata"}, get_rd(d), got.rdata);
        check({tag, ".fault"}, 32'(get_rf(d)), 32'(got.fault));
        @(negedge clock);
        check({tag, ".pulse"}, {get_rv(d), get_rf(d), 30'(get_rd(d))}, 32'd0);
    endtask

    function automatic logic [31:0] mdl_load(input logic [31:0] a, input write_width_t wd,
                                             input logic u);
        logic [31:0] v = '0;
        for (int i = 0; i < size_of(wd); i++) v[8*i +: 8] = mdl[a[9:0] + 10'(i)];
        if (wd == write_byte && !u)     v = {{24{v[7]}}, v[7:0]};
        if (wd == write_halfword && !u) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic mdl_store(input logic [31:0] a, input write_width_t wd, input logic [31:0] v);
        for (int i = 0; i < size_of(wd); i++) mdl[a[9:0] + 10'(i)] = v[8*i +: 8];
    endtask

    initial begin
        logic [31:0] ra, rv;
        write_width_t rw;
        logic rwr, ru;
        drive(0, 1'b0, 1'b0, '0, write_word, 1'b0, '0);
        drive(1, 1'b0, 1'b0, '0, write_word, 1'b0, '0);
        repeat (3) @(negedge clock);
        check("rst_a", {if_a.req_ready, if_a.resp_valid, if_a.resp_fault, 29'(if_a.resp_rdata)}, 32'h8000_0000);
        check("rst_f", {if_f.req_ready, if_f.resp_valid, if_f.resp_fault, 29'(if_f.resp_rdata)}, 32'h8000_0000);
        reset = 1'b0;

        // Aligned word and sub-word accesses
        xact("t1_st",  0, 1, 32'h10, write_word, 0, 32'h8765_4321, 32'h0, 0);
        xact("t1_ld",  0, 0, 32'h10, write_word, 0, 32'h0, 32'h8765_4321, 0);
        xact("t2_sth", 0, 1, 32'h12, write_halfword, 0, 32'h0000_FEDC, 32'h0, 0);
        xact("t2_lbs", 0, 0, 32'h13, write_byte, 0, 32'h0, 32'hFFFF_FFFE, 0);
        xact("t2_lbu", 0, 0, 32'h13, write_byte, 1, 32'h0, 32'h0000_00FE, 0);
        xact("t2_lw",  0, 0, 32'h10, write_word, 0, 32'h0, 32'hFEDC_4321, 0);
        xact("t2_lhs", 0, 0, 32'h11, write_halfword, 0, 32'h0, 32'hFFFF_DC43, 0);

        // Split store/load across a word boundary
        xact("t3_i0",  0, 1, 32'h20, write_word, 0, 32'h1122_3344, 32'h0, 0);
        xact("t3_i1",  0, 1, 32'h24, write_word, 0, 32'h5566_7788, 32'h0, 0);
        xact("t3_st",  0, 1, 32'h21, write_word, 0, 32'hAABB_CCDD, 32'h0, 0);
        xact("t3_ld",  0, 0, 32'h21, write_word, 0, 32'h0, 32'hAABB_CCDD, 0);
        xact("t3_w0",  0, 0, 32'h20, write_word, 0, 32'h0, 32'hBBCC_DD44, 0);
        xact("t3_w1",  0, 0, 32'h24, write_word, 0, 32'h0, 32'h5566_77AA, 0);
        xact("t3_lh",  0, 0, 32'h23, write_halfword, 1, 32'h0, 32'h0000_AABB, 0);

        // Top-of-range behaviour
        xact("t5_i",   0, 1, 32'h3FC, write_word, 0, 32'hA500_0000, 32'h0, 0);
        xact("t5_lh",  0, 0, 32'h3FF, write_halfword, 0, 32'h0, 32'h0, 1);
        xact("t5_lbs", 0, 0, 32'h3FF, write_byte, 0, 32'h0, 32'hFFFF_FFA5, 0);
        xact("t5_lbu", 0, 0, 32'h3FF, write_byte, 1, 32'h0, 32'h0000_00A5, 0);
        xact("t5_sw",  0, 1, 32'h400, write_word, 0, 32'hDEAD_BEEF, 32'h0, 1);
        xact("t5_sh",  0, 1, 32'h3FF, write_halfword, 0, 32'h0000_1234, 32'h0, 1);
        xact("t5_sw2", 0, 1, 32'h3FE, write_word, 0, 32'h5555_5555, 32'h0, 1);
        xact("t5_rb",  0, 0, 32'h3FC, write_word, 0, 32'h0, 32'hA500_0000, 0);

        // Faulting instance: misalignment and range around a non-zero base
        xact("t4_i0",  1, 1, 32'h1020, write_word, 0, 32'h1111_1111, 32'h0, 0);
        xact("t4_i1",  1, 1, 32'h1024, write_word, 0, 32'h2222_2222, 32'h0, 0);
        xact("t4_st",  1, 1, 32'h1021, write_word, 0, 32'hAABB_CCDD, 32'h0, 1);
        xact("t4_w0",  1, 0, 32'h1020, write_word, 0, 32'h0, 32'h1111_1111, 0);
        xact("t4_w1",  1, 0, 32'h1024, write_word, 0, 32'h0, 32'h2222_2222, 0);
        xact("t4_lh1", 1, 0, 32'h1021, write_halfword, 1, 32'h0, 32'h0000_1111, 0);
        xact("t4_lh3", 1, 0, 32'h1023, write_halfword, 1, 32'h0, 32'h0, 1);
        xact("f_below",1, 0, 32'h0FFF, write_byte, 1, 32'h0, 32'h0, 1);
        xact("f_topst",1, 1, 32'h10FF, write_byte, 0, 32'h0000_005A, 32'h0, 0);
        xact("f_topld",1, 0, 32'h10FF, write_byte, 1, 32'h0, 32'h0000_005A, 0);
        xact("f_above",1, 0, 32'h1100, write_byte, 1, 32'h0, 32'h0, 1);

        // Reset during ACC0 drops the store
        xact("t6_i",   0, 1, 32'h30, write_word, 0, 32'hCAFE_F00D, 32'h0, 0);
        @(negedge clock);
        drive(0, 1'b1, 1'b1, 32'h30, write_word, 1'b0, 32'h1234_5678);
        @(posedge clock);
        #1;
        drive(0, 1'b0, 1'b0, '0, write_word, 1'b0, '0);
        reset = 1'b1;
        @(negedge clock);
        check("t6_rst", {if_a.req_ready, if_a.resp_valid, if_a.resp_fault, 29'(if_a.resp_rdata)}, 32'h8000_0000);
        reset = 1'b0;
        xact("t6_rb",  0, 0, 32'h30, write_word, 0, 32'h0, 32'hCAFE_F00D, 0);

        // Random traffic against a byte-level model
        for (int i = 0; i < 16; i++) begin
            ra = 32'h40 + 32'(4 * i);
            rv = $urandom;
            mdl_store(ra, write_word, rv);
            xact("rnd_init", 0, 1, ra, write_word, 0, rv, 32'h0, 0);
        end
        for (int i = 0; i < 30; i++) begin
            ra  = 32'h40 + 32'($urandom_range(0, 59));
            rv  = $urandom;
            rw  = write_width_t'($urandom_range(0, 2));
            rwr = 1'($urandom_range(0, 1));
            ru  = 1'($urandom_range(0, 1));
            if (rwr) begin
                mdl_store(ra, rw, rv);
                xact("rnd_st", 0, 1, ra, rw, ru, rv, 32'h0, 0);
            end else begin
                xact("rnd_ld", 0, 0, ra, rw, ru, rv, mdl_load(ra, rw, ru), 0);
            end
        end

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
